// File: rtl/prm_cmd_pkg.sv
// rtl/prm_cmd_pkg.sv - shared command codes, field widths and state encoding for the parameter queue
package prm_cmd_pkg;

  localparam int WORD_W    = 32;
  localparam int CMD_W     = 4;
  localparam int PAYLOAD_W = WORD_W - CMD_W;
  localparam int LEVEL_W   = 5;
  localparam int ERR_W     = 8;

  localparam logic [CMD_W-1:0] CMD_PARAM = 4'hA;
  localparam logic [CMD_W-1:0] CMD_FLUSH = 4'h5;
  localparam logic [CMD_W-1:0] CMD_NOP   = 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HEAD = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DEC_NONE    = 2'd0,
    DEC_PARAM   = 2'd1,
    DEC_FLUSH   = 2'd2,
    DEC_INVALID = 2'd3
  } dec_e;

  function automatic dec_e decode_cmd(input logic [CMD_W-1:0] cmd);
    dec_e kind;
    case (cmd)
      CMD_PARAM: kind = DEC_PARAM;
      CMD_FLUSH: kind = DEC_FLUSH;
      CMD_NOP:   kind = DEC_NONE;
      default:   kind = DEC_INVALID;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/prm_fifo.sv
// rtl/prm_fifo.sv - synchronous FIFO with clear, level count and drop indication
module prm_fifo
  import prm_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               do_push, do_pop;

  assign o_full  = (level_q == LEVEL_W'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_data  = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a push while full is still accepted then.
  assign do_pop  = i_pop && !o_empty && !i_clear && !i_rst;
  assign do_push = i_push && (!o_full || do_pop) && !i_clear && !i_rst;
  assign o_drop  = i_push && o_full && !do_pop && !i_clear && !i_rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LEVEL_W'(1);
        2'b01:   level_d = level_q - LEVEL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/prm_cmd_queue.sv
// rtl/prm_cmd_queue.sv - decodes SPI command words and releases queued parameters to the trigger generator
module prm_cmd_queue
  import prm_cmd_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter bit SYNC_TO_HEAD = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx_valid,
  input  logic [WORD_W-1:0]  i_rx_data,
  input  logic               i_head_flag,
  output logic               o_prm_we,
  output logic [WORD_W-1:0]  o_prm_data,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_overflow,
  output logic [ERR_W-1:0]   o_err_cnt
);

  state_e                 state_q, state_d;
  dec_e                   cmd_kind;
  logic                   is_param, is_flush, is_invalid;
  logic                   fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [PAYLOAD_W-1:0]   fifo_data;
  logic [WORD_W-1:0]      prm_data_q, prm_data_d;
  logic                   overflow_q, overflow_d;
  logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;

  assign cmd_kind   = i_rx_valid ? decode_cmd(i_rx_data[WORD_W-1 -: CMD_W]) : DEC_NONE;
  assign is_param   = (cmd_kind == DEC_PARAM);
  assign is_flush   = (cmd_kind == DEC_FLUSH);
  assign is_invalid = (cmd_kind == DEC_INVALID);

  prm_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (is_flush),
    .i_push  (is_param),
    .i_data  (i_rx_data[PAYLOAD_W-1:0]),
    .i_pop   (fifo_pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level),
    .o_drop  (fifo_drop)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A flush in the same cycle suppresses starting on a word that is about to vanish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !is_flush) state_d = SYNC_TO_HEAD ? ST_WAIT_HEAD : ST_ISSUE;
      end
      ST_WAIT_HEAD: begin
        if (is_flush)         state_d = ST_IDLE;
        else if (i_head_flag) state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_prm_we = 1'b0;
    fifo_pop = 1'b0;
    if (state_q == ST_ISSUE) begin
      o_prm_we = 1'b1;
      fifo_pop = 1'b1;
    end
  end

  // Capture the head word on entry to ISSUE so the data is registered alongside the strobe.
  always_comb begin
    prm_data_d = prm_data_q;
    if (state_d == ST_ISSUE && state_q != ST_ISSUE) prm_data_d = {{CMD_W{1'b0}}, fifo_data};
  end

  always_comb begin
    overflow_d = overflow_q;
    if (is_flush)       overflow_d = 1'b0;
    else if (fifo_drop) overflow_d = 1'b1;
    err_cnt_d = err_cnt_q;
    if (is_invalid && err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prm_data_q <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      prm_data_q <= prm_data_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_prm_data = prm_data_q;
  assign o_overflow = overflow_q;
  assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_prm_cmd_queue.sv
// tb/tb_prm_cmd_queue.sv - directed self-checking bench for prm_cmd_queue in both release modes
module tb_prm_cmd_queue;

  logic        clk = 1'b0;
  logic        rst0, rx_valid0, head0;
  logic [31:0] rx_data0;
  logic        rst1, rx_valid1, head1;
  logic [31:0] rx_data1;

  logic        we0, we1, ov0, ov1;
  logic [31:0] data0, data1;
  logic [4:0]  level0, level1;
  logic [7:0]  err0, err1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prm_cmd_queue #(.DEPTH(4), .SYNC_TO_HEAD(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst0), .i_rx_valid(rx_valid0), .i_rx_data(rx_data0),
    .i_head_flag(head0), .o_prm_we(we0), .o_prm_data(data0), .o_level(level0),
    .o_overflow(ov0), .o_err_cnt(err0)
  );

  prm_cmd_queue #(.DEPTH(4), .SYNC_TO_HEAD(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_rx_valid(rx_valid1), .i_rx_data(rx_data1),
    .i_head_flag(head1), .o_prm_we(we1), .o_prm_data(data1), .o_level(level1),
    .o_overflow(ov1), .o_err_cnt(err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("%s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [31:0] w);
    if (d == 0) begin rx_valid0 = 1'b1; rx_data0 = w; end
    else        begin rx_valid1 = 1'b1; rx_data1 = w; end
    tick();
    rx_valid0 = 1'b0;
    rx_valid1 = 1'b0;
  endtask

  task automatic pulse_head();
    head1 = 1'b1;
    tick();
    head1 = 1'b0;
  endtask

  // Head pulse while waiting: strobe in the following cycle, then back to WAIT_HEAD after 3 cycles.
  task automatic head_expect(input string tag, input logic [31:0] exp);
    pulse_head();
    check({tag, "_we"}, {31'd0, we1}, 32'd1);
    check({tag, "_data"}, data1, exp);
    tick();
    check({tag, "_gap"}, {31'd0, we1}, 32'd0);
    tick();
    tick();
  endtask

  initial begin
    rst0 = 1'b1; rx_valid0 = 1'b0; rx_data0 = '0; head0 = 1'b0;
    rst1 = 1'b1; rx_valid1 = 1'b0; rx_data1 = '0; head1 = 1'b0;
    tick();
    tick();
    rst0 = 1'b0;
    rst1 = 1'b0;
    check("rst0_we", {31'd0, we0}, 32'd0);
    check("rst0_data", data0, 32'd0);
    check("rst0_level", {27'd0, level0}, 32'd0);
    check("rst0_ov", {31'd0, ov0}, 32'd0);
    check("rst0_err", {24'd0, err0}, 32'd0);
    check("rst1_we", {31'd0, we1}, 32'd0);
    check("rst1_data", data1, 32'd0);
    check("rst1_level", {27'd0, level1}, 32'd0);
    check("rst1_ov", {31'd0, ov1}, 32'd0);
    check("rst1_err", {24'd0, err1}, 32'd0);

    // Immediate release: strobe two cycles after the receive cycle.
    push(0, 32'hA000_0123);
    check("imm_c1_we", {31'd0, we0}, 32'd0);
    check("imm_c1_level", {27'd0, level0}, 32'd1);
    tick();
    check("imm_c2_we", {31'd0, we0}, 32'd1);
    check("imm_c2_data", data0, 32'h0000_0123);
    tick();
    check("imm_c3_we", {31'd0, we0}, 32'd0);
    check("imm_c3_level", {27'd0, level0}, 32'd0);

    // Head-synchronised release, heads 10 cycles apart.
    push(1, 32'hA000_0011);
    push(1, 32'hA000_0022);
    push(1, 32'hA000_0033);
    tick();
    check("sync_level3", {27'd0, level1}, 32'd3);
    check("sync_prehead_we", {31'd0, we1}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      pulse_head();
      check("sync_we", {31'd0, we1}, 32'd1);
      check("sync_data", data1, 32'h0000_0011 * (k + 1));
      for (int j = 0; j < 9; j++) begin
        tick();
        check("sync_quiet", {31'd0, we1}, 32'd0);
      end
    end
    check("sync_level0", {27'd0, level1}, 32'd0);

    // Overflow: fifth word dropped and never emitted.
    for (int i = 1; i <= 5; i++) push(1, 32'hA000_0100 + i);
    check("ovf_level", {27'd0, level1}, 32'd4);
    check("ovf_flag", {31'd0, ov1}, 32'd1);
    tick();
    for (int i = 1; i <= 4; i++) head_expect("ovf_drain", 32'h0000_0100 + i);
    pulse_head();
    check("ovf_fifth_we", {31'd0, we1}, 32'd0);
    tick();
    check("ovf_fifth_we2", {31'd0, we1}, 32'd0);
    check("ovf_empty", {27'd0, level1}, 32'd0);
    check("ovf_sticky", {31'd0, ov1}, 32'd1);

    // Flush with words queued and overflow set.
    push(1, 32'hA000_0301);
    push(1, 32'hA000_0302);
    check("fl_level2", {27'd0, level1}, 32'd2);
    push(1, 32'h5000_0000);
    check("fl_level0", {27'd0, level1}, 32'd0);
    check("fl_ov0", {31'd0, ov1}, 32'd0);
    pulse_head();
    check("fl_head_we", {31'd0, we1}, 32'd0);
    tick();
    check("fl_head_we2", {31'd0, we1}, 32'd0);

    // Invalid commands count and saturate; NOP is ignored.
    push(1, 32'hA000_0401);
    push(1, 32'h3000_0000);
    push(1, 32'hF000_0001);
    check("err_two", {24'd0, err1}, 32'd2);
    check("err_level", {27'd0, level1}, 32'd1);
    for (int i = 0; i < 300; i++) push(1, 32'h7000_0000 | i);
    check("err_sat", {24'd0, err1}, 32'd255);
    push(1, 32'h0000_0000);
    check("nop_err", {24'd0, err1}, 32'd255);
    check("nop_level", {27'd0, level1}, 32'd1);

    // Reset while waiting for a head with three words queued; receive during reset ignored.
    push(1, 32'hA000_0402);
    push(1, 32'hA000_0403);
    check("rw_level3", {27'd0, level1}, 32'd3);
    rst1 = 1'b1;
    rx_valid1 = 1'b1;
    rx_data1 = 32'hA000_0999;
    tick();
    rst1 = 1'b0;
    rx_valid1 = 1'b0;
    check("rw_we", {31'd0, we1}, 32'd0);
    check("rw_data", data1, 32'd0);
    check("rw_level", {27'd0, level1}, 32'd0);
    check("rw_ov", {31'd0, ov1}, 32'd0);
    check("rw_err", {24'd0, err1}, 32'd0);
    pulse_head();
    check("rw_head_we", {31'd0, we1}, 32'd0);
    tick();
    check("rw_head_we2", {31'd0, we1}, 32'd0);

    // Push during the popping cycle while full is accepted; order preserved through wrap.
    for (int i = 1; i <= 4; i++) push(1, 32'hA000_0200 + i);
    tick();
    pulse_head();
    check("pp_we", {31'd0, we1}, 32'd1);
    check("pp_data", data1, 32'h0000_0201);
    push(1, 32'hA000_0205);
    check("pp_level", {27'd0, level1}, 32'd4);
    check("pp_ov", {31'd0, ov1}, 32'd0);
    tick();
    tick();
    for (int i = 2; i <= 5; i++) head_expect("pp_drain", 32'h0000_0200 + i);
    check("pp_empty", {27'd0, level1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prm_cmd_queue.md
PRM_CMD_QUEUE -- requirements
Module: prm_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue depth in words (power of two, 2..16).
REQ-002 SHALL have parameter SYNC_TO_HEAD, default 1: 1 = release one word per pattern head, 0 = release immediately.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_rx_valid, input, 1 bit: one-cycle strobe marking a received SPI word.
REQ-006 SHALL have port i_rx_data, input, 32 bits: received word; [31:28] = command, [27:0] = payload.
REQ-007 SHALL have port i_head_flag, input, 1 bit: one-cycle pulse at the start of each column-pattern sequence, from the trigger generator.
REQ-008 SHALL have port o_prm_we, output, 1 bit: one-cycle parameter write strobe to the trigger generator.
REQ-009 SHALL have port o_prm_data, output, 32 bits: parameter word {4'b0000, payload}.
REQ-010 SHALL have port o_level, output, 5 bits: current queue occupancy.
REQ-011 SHALL have port o_overflow, output, 1 bit: sticky flag, set when a word is dropped because the queue is full.
REQ-012 SHALL have port o_err_cnt, output, 8 bits: count of invalid command words.

Function
REQ-013 SHALL decode the command nibble on i_rx_valid: 4'hA = PARAM (enqueue payload), 4'h5 = FLUSH, 4'h0 = NOP (ignored); any other value = invalid (word dropped, o_err_cnt +1, saturating at 255).
REQ-014 SHALL implement the states IDLE, WAIT_HEAD, ISSUE and GAP.
REQ-015 SHALL make these transitions: IDLE -> WAIT_HEAD when the queue is non-empty and SYNC_TO_HEAD = 1; IDLE -> ISSUE when non-empty and SYNC_TO_HEAD = 0; WAIT_HEAD -> ISSUE on i_head_flag; ISSUE -> GAP (pop, one cycle); GAP -> IDLE.
REQ-016 SHALL assert o_prm_we for exactly one cycle in ISSUE, with o_prm_data registered and stable in that same cycle.
REQ-017 SHALL, with SYNC_TO_HEAD = 0 and an empty queue, assert o_prm_we exactly 2 cycles after the i_rx_valid cycle.
REQ-018 SHALL, with SYNC_TO_HEAD = 1, assert o_prm_we 1 cycle after the i_head_flag pulse that is seen in WAIT_HEAD; head pulses seen in any other state SHALL be ignored.
REQ-019 SHALL release at most one word per head pulse, and leave at least one idle cycle (GAP) between successive o_prm_we pulses.
REQ-020 SHALL, on a push while full with no pop in the same cycle, drop the word and set o_overflow; a push and a pop in the same cycle while full SHALL accept the push.
REQ-021 SHALL, on FLUSH, empty the queue on the next cycle, clear o_overflow, and return WAIT_HEAD to IDLE; an ISSUE already in progress SHALL complete.
REQ-022 SHALL update o_level in the cycle after each push or pop; a simultaneous push and pop SHALL leave it unchanged.
REQ-023 SHALL preserve FIFO order; read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-024 SHALL, with i_rst high at a clock edge, return to IDLE and clear the pointers, o_level, o_overflow and o_err_cnt to 0, and drive o_prm_we = 0 and o_prm_data = 0.
REQ-025 SHALL discard a reset mid-issue (no partial strobe); i_rx_valid during reset SHALL be ignored.

Structure
REQ-026 SHALL place the command codes (CMD_PARAM, CMD_FLUSH, CMD_NOP), the field widths and the state encoding in the shared package prm_cmd_pkg.
REQ-027 SHALL implement storage as one sub-module, prm_fifo (synchronous FIFO with push, pop, full, empty, level and clear).

Verification
REQ-028 SHALL cover: SYNC_TO_HEAD = 0, push 0xA0000123 -> o_prm_we at +2 cycles with o_prm_data = 0x00000123, then o_level = 0.
REQ-029 SHALL cover: SYNC_TO_HEAD = 1, push 3 PARAM words, then 3 head pulses 10 cycles apart -> 3 strobes, each 1 cycle after its head, in order.
REQ-030 SHALL cover: DEPTH = 4, 5 pushes with no head -> o_level = 4, o_overflow = 1, 5th word absent from the output.
REQ-031 SHALL cover: push 0x30000000 and 0xF0000001 -> o_err_cnt = 2, o_level unchanged; push 300 invalid words -> o_err_cnt = 255.
REQ-032 SHALL cover: 2 words queued plus o_overflow set, then push 0x50000000 -> o_level = 0, o_overflow = 0, no o_prm_we on the next head.
REQ-033 SHALL cover: i_rst asserted during WAIT_HEAD with 3 words queued -> all outputs 0 the next cycle, no strobe on the following head.
